// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch unit and its neighbours:
// default widths, reset PC and the fetch FSM state encoding.
package instr_fetch_pkg;

    localparam int          DEF_ADDR_W   = 16;
    localparam int          DEF_DATA_W   = 16;
    localparam logic [15:0] DEF_RESET_PC = 16'h0000;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_pc_reg.sv
// Program counter register: reset value, redirect load and +1 advance.
// A redirect always beats the increment so a branch taken in the same
// cycle as an accepted fetch lands on the target, not on pc+1.
module instr_fetch_pc_reg #(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_pc,
    input  logic              incr,
    output logic [ADDR_W-1:0] pc
);

    // PC update: reset > redirect > increment (wraps naturally at 2^ADDR_W)
    always_ff @(posedge clk) begin
        if (!reset)
            pc <= RESET_PC;
        else if (load)
            pc <= load_pc;
        else if (incr)
            pc <= pc + ADDR_W'(1);
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit. Issues one read at a time to instruction memory,
// holds the returned word for the control statemachine until it is acked,
// and drops any response that a redirect or reset has made stale.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter int                DATA_W   = DEF_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_valid,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ack,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt
);

    fetch_state_t      state;
    logic              discard;
    logic [ADDR_W-1:0] pc;
    logic              accept;

    // A response is kept only if nothing made it stale, including a
    // redirect arriving in the very cycle the data returns.
    assign accept   = (state == S_WAIT) && mem_valid && !discard && !redirect;

    // The request goes out in the FETCH cycle itself; halt only gates it.
    assign mem_rd   = reset && (state == S_FETCH) && !halt;
    assign mem_addr = pc;

    instr_fetch_pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk     (clk),
        .reset   (reset),
        .load    (redirect),
        .load_pc (redirect_pc),
        .incr    (accept),
        .pc      (pc)
    );

    // Fetch FSM, discard flag and the held instruction register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= S_FETCH;
            // a request abandoned mid-flight still owes us one response
            discard     <= (state == S_WAIT);
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (!halt) begin
                        state   <= S_WAIT;
                        // a redirect now means this request carries the old pc
                        discard <= discard | redirect;
                    end
                end
                S_WAIT: begin
                    if (mem_valid) begin
                        if (discard || redirect) begin
                            discard <= 1'b0;
                            state   <= S_FETCH;
                        end else begin
                            instr       <= mem_rdata;
                            instr_pc    <= pc;
                            instr_valid <= 1'b1;
                            state       <= S_HOLD;
                        end
                    end else if (redirect) begin
                        discard <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (instr_ack || redirect) begin
                        instr_valid <= 1'b0;
                        state       <= S_FETCH;
                    end
                end
                default: begin
                    state       <= S_FETCH;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios with literal expectations plus a
// long randomized run checked every cycle against a transaction-level model
// (one outstanding request, one held word, stale-on-redirect bookkeeping).
module tb_instr_fetch;

    logic        clk;
    logic        reset;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic [15:0] mem_rdata;
    logic        mem_valid;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        instr_valid;
    logic        instr_ack;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        halt;

    instr_fetch dut (
        .clk         (clk),
        .reset       (reset),
        .mem_rd      (mem_rd),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .mem_valid   (mem_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ack   (instr_ack),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [15:0] data;
    } resp_t;

    logic [15:0] mem_arr [0:65535];
    resp_t       pend_q [$];
    int          rd_q [$];
    logic [15:0] acc_i [$];
    logic [15:0] acc_p [$];

    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  force_lat = 1;
    int  lat;
    bit  model_on = 1'b1;
    bit  spurious = 1'b0;
    bit  saw_dead = 1'b0;

    // transaction-level reference state
    logic [15:0] m_pc, m_instr, m_ipc;
    bit          m_out, m_stale, m_hold, exp_rd;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // advance one clock; memory outputs for the new cycle are driven at edge+1
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
            mem_valid = 1'b1;
            mem_rdata = pend_q[0].data;
            void'(pend_q.pop_front());
        end else begin
            mem_valid = spurious;
            mem_rdata = 16'($urandom);
        end
    endtask

    task automatic rst_pulse();
        reset = 1'b0; halt = 1'b0; instr_ack = 1'b0; redirect = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        rd_q.delete(); acc_i.delete(); acc_p.delete();
    endtask

    task automatic wait_rd(input string nm, input logic [15:0] addr);
        int n = 0;
        #1;
        while (!mem_rd && n < 20) begin tick(); #1; n++; end
        if (!mem_rd) begin
            checks++; errors++;
            $display("FAIL %s: timeout waiting for mem_rd, expected addr %0h", nm, addr);
        end else
            chk(nm, 32'(mem_addr), 32'(addr));
    endtask

    task automatic wait_valid(input string nm);
        int n = 0;
        while (!instr_valid && n < 20) begin tick(); n++; end
        if (!instr_valid) begin
            checks++; errors++;
            $display("FAIL %s: timeout waiting for instr_valid, got 0 expected 1", nm);
        end
    endtask

    // Memory responder, logs and the per-cycle model compare
    always @(negedge clk) begin
        if (reset && mem_rd) begin
            lat = (force_lat != 0) ? force_lat : int'($urandom_range(1, 3));
            pend_q.push_back('{cyc + lat, mem_arr[mem_addr]});
            rd_q.push_back(cyc);
        end
        if (reset && instr_valid && instr_ack) begin
            acc_i.push_back(instr);
            acc_p.push_back(instr_pc);
        end
        if (reset && instr == 16'hDEAD) saw_dead = 1'b1;

        if (!reset) begin
            if (model_on) chk("rst_mem_rd", 32'(mem_rd), 0);
            m_pc = 16'h0000; m_instr = 16'h0000; m_ipc = 16'h0000;
            m_out = 1'b0; m_stale = 1'b0; m_hold = 1'b0;
        end else if (model_on) begin
            exp_rd = !m_out && !m_hold && !halt;
            chk("m_instr_valid", 32'(instr_valid), 32'(m_hold));
            chk("m_instr", 32'(instr), 32'(m_instr));
            chk("m_instr_pc", 32'(instr_pc), 32'(m_ipc));
            chk("m_mem_rd", 32'(mem_rd), 32'(exp_rd));
            if (exp_rd && mem_rd) chk("m_mem_addr", 32'(mem_addr), 32'(m_pc));
            if (instr_valid) chk("instr_vs_mem", 32'(instr), 32'(mem_arr[instr_pc]));
            if (mem_valid && m_out) begin
                m_out = 1'b0;
                if (!m_stale && !redirect) begin
                    m_hold = 1'b1; m_instr = mem_rdata; m_ipc = m_pc; m_pc = m_pc + 16'd1;
                end
            end else if (m_hold && (instr_ack || redirect)) begin
                m_hold = 1'b0;
            end else if (exp_rd) begin
                m_out = 1'b1; m_stale = redirect;
            end else if (m_out && redirect) begin
                m_stale = 1'b1;
            end
            if (redirect) m_pc = redirect_pc;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [15:0] held;

    initial begin
        for (int i = 0; i < 65536; i++) mem_arr[i] = 16'((i * 31) ^ 16'h5A3C);
        reset = 1'b0; halt = 1'b0; instr_ack = 1'b0; redirect = 1'b0;
        redirect_pc = 16'h0000; mem_valid = 1'b0; mem_rdata = 16'h0000;

        // 1: reset values, first fetch with 1-cycle memory
        mem_arr[0] = 16'h2040;
        tick(); tick();
        chk("rst_valid", 32'(instr_valid), 0);
        chk("rst_instr", 32'(instr), 0);
        chk("rst_instr_pc", 32'(instr_pc), 0);
        reset = 1'b1;
        #1;
        chk("t1_rd", 32'(mem_rd), 1);
        chk("t1_addr", 32'(mem_addr), 0);
        tick();
        chk("t1_wait_valid", 32'(instr_valid), 0);
        tick();
        chk("t1_valid", 32'(instr_valid), 1);
        chk("t1_instr", 32'(instr), 32'h2040);
        chk("t1_instr_pc", 32'(instr_pc), 0);

        // 2: ack every word, one instruction per 3 cycles
        for (int i = 0; i < 4; i++) mem_arr[i] = 16'(16'hA0A0 + i * 16'h0101);
        rst_pulse();
        for (int j = 0; j < 14; j++) begin instr_ack = instr_valid; tick(); end
        instr_ack = 1'b0;
        chk("t2_count_ok", 32'(acc_i.size() >= 4), 1);
        for (int i = 0; i < 4 && i < acc_i.size(); i++) begin
            chk("t2_instr", 32'(acc_i[i]), 32'(16'hA0A0 + i * 16'h0101));
            chk("t2_instr_pc", 32'(acc_p[i]), 32'(i));
        end
        for (int i = 1; i < 4 && i < rd_q.size(); i++)
            chk("t2_rd_spacing", 32'(rd_q[i] - rd_q[i-1]), 3);

        // 3: redirect while waiting; stale DEAD must never surface
        mem_arr[0] = 16'hDEAD;
        mem_arr[16'h0080] = 16'h0880;
        force_lat = 3;
        rst_pulse();
        saw_dead = 1'b0;
        tick();
        redirect = 1'b1; redirect_pc = 16'h0080;
        tick();
        redirect = 1'b0;
        tick(); tick();
        chk("t3_no_valid", 32'(instr_valid), 0);
        force_lat = 1;
        wait_rd("t3_addr", 16'h0080);
        wait_valid("t3_valid");
        chk("t3_instr", 32'(instr), 32'h0880);
        chk("t3_instr_pc", 32'(instr_pc), 32'h0080);
        chk("t3_dead_seen", 32'(saw_dead), 0);

        // 4: redirect and ack together in HOLD
        redirect = 1'b1; redirect_pc = 16'h1234; instr_ack = 1'b1;
        tick();
        redirect = 1'b0; instr_ack = 1'b0;
        chk("t4_drop", 32'(instr_valid), 0);
        wait_rd("t4_addr", 16'h1234);
        wait_valid("t4_valid");
        chk("t4_instr_pc", 32'(instr_pc), 32'h1234);

        // 5: pc wraps from FFFF to 0000
        redirect = 1'b1; redirect_pc = 16'hFFFF;
        tick();
        redirect = 1'b0;
        wait_rd("t5_addr", 16'hFFFF);
        wait_valid("t5_valid");
        chk("t5_instr_pc", 32'(instr_pc), 32'hFFFF);
        instr_ack = 1'b1;
        tick();
        instr_ack = 1'b0;
        wait_rd("t5_wrap", 16'h0000);
        wait_valid("t5_valid2");

        // 6: halt blocks new requests; reset in WAIT discards a late response
        halt = 1'b1; instr_ack = 1'b1;
        tick();
        instr_ack = 1'b0;
        for (int j = 0; j < 3; j++) begin #1; chk("t6_halt_rd", 32'(mem_rd), 0); tick(); end
        halt = 1'b0;
        #1;
        chk("t6_resume", 32'(mem_rd), 1);
        chk("t6_resume_addr", 32'(mem_addr), 32'h0001);
        force_lat = 4;
        tick();
        model_on = 1'b0;
        reset = 1'b0; halt = 1'b1;
        tick();
        chk("t6_rst_valid", 32'(instr_valid), 0);
        reset = 1'b1;
        tick(); tick(); tick();
        #1;
        chk("t6_halt_after_rst", 32'(mem_rd), 0);
        chk("t6_late_ignored", 32'(instr_valid), 0);
        force_lat = 1;
        halt = 1'b0;
        #1;
        chk("t6_rd_after_rst", 32'(mem_rd), 1);
        chk("t6_pc_reset", 32'(mem_addr), 0);
        tick(); tick();
        chk("t6_discard", 32'(instr_valid), 0);
        wait_rd("t6_refetch", 16'h0000);
        wait_valid("t6_valid");
        chk("t6_instr_pc", 32'(instr_pc), 0);
        chk("t6_instr", 32'(instr), 32'(mem_arr[0]));
        held = instr;
        spurious = 1'b1;
        tick();
        spurious = 1'b0;
        chk("t6_spurious_valid", 32'(instr_valid), 1);
        chk("t6_spurious_instr", 32'(instr), 32'(held));

        // randomized run against the model
        rst_pulse();
        model_on = 1'b1;
        force_lat = 0;
        for (int j = 0; j < 3000; j++) begin
            reset       = !(instr_valid && ($urandom_range(0, 99) == 0));
            halt        = ($urandom_range(0, 7) == 0);
            redirect    = ($urandom_range(0, 11) == 0);
            redirect_pc = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
            instr_ack   = ($urandom_range(0, 2) != 0);
            tick();
        end
        reset = 1'b1; halt = 1'b0; redirect = 1'b0; instr_ack = 1'b0;
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
